// File: rtl/serial_frame_rx_pkg.sv
`default_nettype none
// ============================================================================
// Package : serial_frame_rx_pkg
// Shared defaults and parser state encoding for the serial frame receiver.
// Rev     : 1.0
// ============================================================================
package serial_frame_rx_pkg;

   localparam logic [7:0] c_sync_byte_dflt = 8'hA5;
   localparam int         c_max_len_dflt   = 16;
   localparam int         c_timeout_dflt   = 2000;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_CMD  = 3'd1,
      ST_LEN  = 3'd2,
      ST_PAY  = 3'd3,
      ST_CHK  = 3'd4
   } state_t;

endpackage
`default_nettype wire

// File: rtl/serial_frame_rx_byte_timeout.sv
`default_nettype none
// ============================================================================
// Module : byte_timeout
// Saturating inter-byte idle counter; expired is high once TIMEOUT is reached.
// Rev    : 1.0
// ============================================================================
module byte_timeout #(
   parameter int TIMEOUT = 2000
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic expired
);
   localparam int                   c_cnt_w = $clog2(TIMEOUT + 1);
   localparam logic [c_cnt_w-1:0]   c_limit = c_cnt_w'(TIMEOUT);

   logic [c_cnt_w-1:0] r_count;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         r_count <= '0;
      end else if (r_count != c_limit) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign expired = (r_count == c_limit);

endmodule
`default_nettype wire

// File: rtl/serial_frame_rx.sv
`default_nettype none
// ============================================================================
// Module : serial_frame_rx
// Parses SYNC/CMD/LEN/payload/CHK byte frames delivered by a serial receiver.
// Rev    : 1.0
// ============================================================================
module serial_frame_rx
   import serial_frame_rx_pkg::*;
#(
   parameter logic [7:0] SYNC_BYTE = c_sync_byte_dflt,
   parameter int         MAX_LEN   = c_max_len_dflt,
   parameter int         TIMEOUT   = c_timeout_dflt
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rx_data,
   input  logic       rx_done,
   output logic [7:0] cmd,
   output logic [4:0] len,
   output logic       wr_en,
   output logic [3:0] wr_addr,
   output logic [7:0] wr_data,
   output logic       frame_valid,
   output logic       frame_err
);
   localparam logic [7:0] c_max_len_b = 8'(MAX_LEN);

   state_t     r_state;
   state_t     w_next_state;
   logic [7:0] r_shadow_cmd;
   logic [7:0] r_xor;
   logic [4:0] r_index;
   logic [4:0] r_len_exp;
   logic [7:0] r_cmd;
   logic [4:0] r_len;
   logic       r_wr_en;
   logic [3:0] r_wr_addr;
   logic [7:0] r_wr_data;
   logic       r_valid;
   logic       r_err;

   logic       w_expired;
   logic       w_to_clear;
   logic       w_last;
   logic       w_load_cmd;
   logic       w_load_len;
   logic       w_accept_pay;
   logic       w_good;
   logic       w_bad;

   assign w_to_clear = rx_done | (r_state == ST_IDLE);
   assign w_last     = (r_index == (r_len_exp - 5'd1));

   byte_timeout #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk     (clk),
      .rst     (rst),
      .clear   (w_to_clear),
      .expired (w_expired)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // A byte strobe always takes priority over an expiring idle counter.
   always_comb begin
      w_next_state = r_state;
      w_load_cmd   = 1'b0;
      w_load_len   = 1'b0;
      w_accept_pay = 1'b0;
      w_good       = 1'b0;
      w_bad        = 1'b0;
      if (rx_done) begin
         case (r_state)
            ST_IDLE: begin
               if (rx_data == SYNC_BYTE) w_next_state = ST_CMD;
            end
            ST_CMD: begin
               w_load_cmd   = 1'b1;
               w_next_state = ST_LEN;
            end
            ST_LEN: begin
               w_load_len = 1'b1;
               if (rx_data == 8'd0) begin
                  w_next_state = ST_CHK;
               end else if (rx_data <= c_max_len_b) begin
                  w_next_state = ST_PAY;
               end else begin
                  w_bad        = 1'b1;
                  w_next_state = ST_IDLE;
               end
            end
            ST_PAY: begin
               w_accept_pay = 1'b1;
               if (w_last) w_next_state = ST_CHK;
            end
            ST_CHK: begin
               if (rx_data == r_xor) w_good = 1'b1;
               else                  w_bad  = 1'b1;
               w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
         endcase
      end else if (w_expired && (r_state != ST_IDLE)) begin
         w_bad        = 1'b1;
         w_next_state = ST_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_shadow_cmd <= '0;
         r_xor        <= '0;
         r_index      <= '0;
         r_len_exp    <= '0;
         r_cmd        <= '0;
         r_len        <= '0;
         r_wr_en      <= 1'b0;
         r_wr_addr    <= '0;
         r_wr_data    <= '0;
         r_valid      <= 1'b0;
         r_err        <= 1'b0;
      end else begin
         r_wr_en <= w_accept_pay;
         r_valid <= w_good;
         r_err   <= w_bad;
         if (w_load_cmd) begin
            r_shadow_cmd <= rx_data;
            r_xor        <= rx_data;
         end
         if (w_load_len) begin
            r_xor     <= r_xor ^ rx_data;
            r_len_exp <= rx_data[4:0];
            r_index   <= '0;
         end
         if (w_accept_pay) begin
            r_xor     <= r_xor ^ rx_data;
            r_index   <= r_index + 5'd1;
            r_wr_addr <= r_index[3:0];
            r_wr_data <= rx_data;
         end
         // Published frame info only changes on a good checksum.
         if (w_good) begin
            r_cmd <= r_shadow_cmd;
            r_len <= r_len_exp;
         end
      end
   end

   assign cmd         = r_cmd;
   assign len         = r_len;
   assign wr_en       = r_wr_en;
   assign wr_addr     = r_wr_addr;
   assign wr_data     = r_wr_data;
   assign frame_valid = r_valid;
   assign frame_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_serial_frame_rx.sv
`default_nettype none
// ============================================================================
// Module : tb_serial_frame_rx
// Scoreboard bench for serial_frame_rx: expected events queued per stimulus.
// Rev    : 1.0
// ============================================================================
module tb_serial_frame_rx;

   localparam logic [7:0] c_sync    = 8'hA5;
   localparam int         c_max_len = 16;
   localparam int         c_timeout = 2000;
   localparam logic [1:0] K_WR      = 2'd0;
   localparam logic [1:0] K_VALID   = 2'd1;
   localparam logic [1:0] K_ERR     = 2'd2;

   typedef struct packed {
      logic [1:0] kind;
      logic [7:0] a;
      logic [7:0] b;
   } ev_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] rx_data;
   logic       rx_done;
   logic [7:0] cmd;
   logic [4:0] len;
   logic       wr_en;
   logic [3:0] wr_addr;
   logic [7:0] wr_data;
   logic       frame_valid;
   logic       frame_err;

   int unsigned cyc = 0;
   int          checks = 0;
   int          passed = 0;
   ev_t         exp_q[$];
   ev_t         obs_q[$];
   int unsigned obs_cyc_q[$];

   serial_frame_rx #(
      .SYNC_BYTE (c_sync),
      .MAX_LEN   (c_max_len),
      .TIMEOUT   (c_timeout)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .rx_data     (rx_data),
      .rx_done     (rx_done),
      .cmd         (cmd),
      .len         (len),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .frame_valid (frame_valid),
      .frame_err   (frame_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic ev_t mk(input logic [1:0] k, input logic [7:0] a, input logic [7:0] b);
      ev_t e;
      e.kind = k;
      e.a    = a;
      e.b    = b;
      return e;
   endfunction

   function automatic string ev_str(input ev_t e);
      return $sformatf("kind=%0d a=%h b=%h", e.kind, e.a, e.b);
   endfunction

   // Output monitor: every DUT event lands in obs_q with its cycle stamp.
   always @(negedge clk) begin
      if (wr_en === 1'b1) begin
         obs_q.push_back(mk(K_WR, {4'h0, wr_addr}, wr_data));
         obs_cyc_q.push_back(cyc);
      end
      if (frame_valid === 1'b1) begin
         obs_q.push_back(mk(K_VALID, cmd, {3'b000, len}));
         obs_cyc_q.push_back(cyc);
      end
      if (frame_err === 1'b1) begin
         obs_q.push_back(mk(K_ERR, 8'h00, 8'h00));
         obs_cyc_q.push_back(cyc);
      end
   end

   task automatic send_byte(input logic [7:0] b);
      rx_data = b;
      rx_done = 1'b1;
      @(negedge clk);
      rx_done = 1'b0;
      rx_data = 8'($urandom);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      rx_done = 1'b0;
      rx_data = 8'h00;
      idle(3);
      checks++;
      if ({cmd, len, wr_en, wr_addr, wr_data, frame_valid, frame_err} !== '0)
         $display("FAIL reset_outputs: got cmd=%h len=%h wr_en=%b wr_addr=%h wr_data=%h valid=%b err=%b, expected all 0",
                  cmd, len, wr_en, wr_addr, wr_data, frame_valid, frame_err);
      else passed++;
      rst = 1'b0;
      idle(2);
      obs_q.delete();
      obs_cyc_q.delete();
   endtask

   task automatic test_good_frame();
      ev_t e, o;
      logic [7:0] bytes [9] = '{8'h00, 8'h5A, 8'hFF, 8'hA5, 8'h01, 8'h02, 8'h11, 8'h22, 8'h30};
      exp_q.push_back(mk(K_WR, 8'h00, 8'h11));
      exp_q.push_back(mk(K_WR, 8'h01, 8'h22));
      exp_q.push_back(mk(K_VALID, 8'h01, 8'h02));
      foreach (bytes[i]) send_byte(bytes[i]);
      idle(5);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) $display("FAIL good_frame: got no event, expected %s", ev_str(e));
         else begin
            o = obs_q.pop_front();
            void'(obs_cyc_q.pop_front());
            if (o !== e) $display("FAIL good_frame: got %s, expected %s", ev_str(o), ev_str(e));
            else passed++;
         end
      end
      checks++;
      if (obs_q.size() != 0) $display("FAIL good_frame_extra: got %0d extra events, expected 0", obs_q.size());
      else passed++;
      obs_q.delete();
      obs_cyc_q.delete();
      idle(10);
      checks++;
      if ({cmd, len} !== {8'h01, 5'd2}) $display("FAIL good_frame_hold: got cmd=%h len=%0d, expected cmd=01 len=2", cmd, len);
      else passed++;
   endtask

   task automatic test_zero_len();
      ev_t e, o;
      logic [7:0] bytes [4] = '{8'hA5, 8'h07, 8'h00, 8'h07};
      exp_q.push_back(mk(K_VALID, 8'h07, 8'h00));
      foreach (bytes[i]) send_byte(bytes[i]);
      idle(5);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) $display("FAIL zero_len: got no event, expected %s", ev_str(e));
         else begin
            o = obs_q.pop_front();
            void'(obs_cyc_q.pop_front());
            if (o !== e) $display("FAIL zero_len: got %s, expected %s", ev_str(o), ev_str(e));
            else passed++;
         end
      end
      checks++;
      if (obs_q.size() != 0) $display("FAIL zero_len_extra: got %0d extra events, expected 0", obs_q.size());
      else passed++;
      obs_q.delete();
      obs_cyc_q.delete();
   endtask

   task automatic test_bad_chk();
      ev_t e, o;
      logic [7:0] bytes [6] = '{8'hA5, 8'h01, 8'h02, 8'h11, 8'h22, 8'h31};
      exp_q.push_back(mk(K_WR, 8'h00, 8'h11));
      exp_q.push_back(mk(K_WR, 8'h01, 8'h22));
      exp_q.push_back(mk(K_ERR, 8'h00, 8'h00));
      foreach (bytes[i]) send_byte(bytes[i]);
      idle(5);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) $display("FAIL bad_chk: got no event, expected %s", ev_str(e));
         else begin
            o = obs_q.pop_front();
            void'(obs_cyc_q.pop_front());
            if (o !== e) $display("FAIL bad_chk: got %s, expected %s", ev_str(o), ev_str(e));
            else passed++;
         end
      end
      checks++;
      if (obs_q.size() != 0) $display("FAIL bad_chk_extra: got %0d extra events, expected 0", obs_q.size());
      else passed++;
      obs_q.delete();
      obs_cyc_q.delete();
      checks++;
      if ({cmd, len} !== {8'h07, 5'd0}) $display("FAIL bad_chk_hold: got cmd=%h len=%0d, expected cmd=07 len=0", cmd, len);
      else passed++;
   endtask

   task automatic test_len_over();
      ev_t e, o;
      logic [7:0] bytes [7] = '{8'hA5, 8'h01, 8'h11, 8'hA5, 8'h02, 8'h00, 8'h02};
      exp_q.push_back(mk(K_ERR, 8'h00, 8'h00));
      exp_q.push_back(mk(K_VALID, 8'h02, 8'h00));
      foreach (bytes[i]) send_byte(bytes[i]);
      idle(5);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) $display("FAIL len_over: got no event, expected %s", ev_str(e));
         else begin
            o = obs_q.pop_front();
            void'(obs_cyc_q.pop_front());
            if (o !== e) $display("FAIL len_over: got %s, expected %s", ev_str(o), ev_str(e));
            else passed++;
         end
      end
      checks++;
      if (obs_q.size() != 0) $display("FAIL len_over_extra: got %0d extra events, expected 0", obs_q.size());
      else passed++;
      obs_q.delete();
      obs_cyc_q.delete();
   endtask

   // Maximum length, back-to-back strobes, sync values inside the payload.
   task automatic test_back_to_back();
      ev_t e, o;
      logic [7:0] pay [16] = '{8'hA5, 8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h02, 8'h03,
                               8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A, 8'hA5};
      logic [7:0] x;
      x = 8'hC3 ^ 8'h10;
      send_byte(c_sync);
      send_byte(8'hC3);
      send_byte(8'h10);
      foreach (pay[i]) begin
         exp_q.push_back(mk(K_WR, 8'(i), pay[i]));
         x = x ^ pay[i];
         send_byte(pay[i]);
      end
      exp_q.push_back(mk(K_VALID, 8'hC3, 8'h10));
      send_byte(x);
      idle(5);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) $display("FAIL back_to_back: got no event, expected %s", ev_str(e));
         else begin
            o = obs_q.pop_front();
            void'(obs_cyc_q.pop_front());
            if (o !== e) $display("FAIL back_to_back: got %s, expected %s", ev_str(o), ev_str(e));
            else passed++;
         end
      end
      checks++;
      if (obs_q.size() != 0) $display("FAIL back_to_back_extra: got %0d extra events, expected 0", obs_q.size());
      else passed++;
      obs_q.delete();
      obs_cyc_q.delete();
   endtask

   task automatic test_timeout();
      ev_t e, o;
      int unsigned t0, tc;
      // Idle after CMD: error registered on the cycle after the counter hits the limit.
      send_byte(c_sync);
      send_byte(8'h01);
      t0 = cyc;
      exp_q.push_back(mk(K_ERR, 8'h00, 8'h00));
      idle(c_timeout + 10);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) $display("FAIL timeout_err: got no event, expected %s", ev_str(e));
         else begin
            o = obs_q.pop_front();
            tc = obs_cyc_q.pop_front();
            if (o !== e) $display("FAIL timeout_err: got %s, expected %s", ev_str(o), ev_str(e));
            else passed++;
            checks++;
            if (tc !== t0 + c_timeout + 1)
               $display("FAIL timeout_cycle: got %0d cycles after byte, expected %0d", tc - t0, c_timeout + 1);
            else passed++;
         end
      end
      checks++;
      if (obs_q.size() != 0) $display("FAIL timeout_extra: got %0d extra events, expected 0", obs_q.size());
      else passed++;
      obs_q.delete();
      obs_cyc_q.delete();
      // A byte arriving exactly as the counter reaches the limit wins.
      exp_q.push_back(mk(K_VALID, 8'h01, 8'h00));
      send_byte(c_sync);
      send_byte(8'h01);
      idle(c_timeout);
      send_byte(8'h00);
      send_byte(8'h01);
      idle(5);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) $display("FAIL timeout_edge: got no event, expected %s", ev_str(e));
         else begin
            o = obs_q.pop_front();
            void'(obs_cyc_q.pop_front());
            if (o !== e) $display("FAIL timeout_edge: got %s, expected %s", ev_str(o), ev_str(e));
            else passed++;
         end
      end
      checks++;
      if (obs_q.size() != 0) $display("FAIL timeout_edge_extra: got %0d extra events, expected 0", obs_q.size());
      else passed++;
      obs_q.delete();
      obs_cyc_q.delete();
   endtask

   task automatic test_reset_mid_frame();
      ev_t e, o;
      logic [7:0] pre  [4] = '{8'hA5, 8'h01, 8'h02, 8'h11};
      logic [7:0] post [5] = '{8'hA5, 8'h03, 8'h01, 8'hA5, 8'hA7};
      exp_q.push_back(mk(K_WR, 8'h00, 8'h11));
      foreach (pre[i]) send_byte(pre[i]);
      idle(1);
      rst = 1'b1;
      idle(2);
      checks++;
      if ({cmd, len, wr_en, wr_addr, wr_data, frame_valid, frame_err} !== '0)
         $display("FAIL mid_reset_outputs: got cmd=%h len=%h wr_en=%b wr_addr=%h wr_data=%h valid=%b err=%b, expected all 0",
                  cmd, len, wr_en, wr_addr, wr_data, frame_valid, frame_err);
      else passed++;
      rst = 1'b0;
      idle(c_timeout + 10);
      exp_q.push_back(mk(K_WR, 8'h00, 8'hA5));
      exp_q.push_back(mk(K_VALID, 8'h03, 8'h01));
      foreach (post[i]) send_byte(post[i]);
      idle(5);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) $display("FAIL mid_reset: got no event, expected %s", ev_str(e));
         else begin
            o = obs_q.pop_front();
            void'(obs_cyc_q.pop_front());
            if (o !== e) $display("FAIL mid_reset: got %s, expected %s", ev_str(o), ev_str(e));
            else passed++;
         end
      end
      checks++;
      if (obs_q.size() != 0) $display("FAIL mid_reset_extra: got %0d extra events, expected 0", obs_q.size());
      else passed++;
      obs_q.delete();
      obs_cyc_q.delete();
   endtask

   initial begin
      test_reset();
      test_good_frame();
      test_zero_len();
      test_bad_chk();
      test_len_over();
      test_back_to_back();
      test_timeout();
      test_reset_mid_frame();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/serial_frame_rx.md
SERIAL_FRAME_RX -- requirements
Module: serial_frame_rx

Interface
REQ-001 SHALL have parameter SYNC_BYTE, default 8'hA5: frame start marker.
REQ-002 SHALL have parameter MAX_LEN, default 16: maximum payload length in bytes (1..16).
REQ-003 SHALL have parameter TIMEOUT, default 2000: inter-byte idle limit in clk cycles (4 byte times at 50 clk/bit).
REQ-004 SHALL have port clk, input, 1: single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port rx_data, input, 8: received byte from the serial receiver; valid only while rx_done=1.
REQ-007 SHALL have port rx_done, input, 1: one-cycle strobe, one new byte per strobe.
REQ-008 SHALL have port cmd, output, 8: command byte of the last good frame.
REQ-009 SHALL have port len, output, 5: payload length of the last good frame.
REQ-010 SHALL have port wr_en, output, 1: payload write strobe.
REQ-011 SHALL have port wr_addr, output, 4: payload byte index, 0-based.
REQ-012 SHALL have port wr_data, output, 8: payload byte.
REQ-013 SHALL have port frame_valid, output, 1: one-cycle pulse, good frame received.
REQ-014 SHALL have port frame_err, output, 1: one-cycle pulse, frame aborted.

Function
REQ-015 Frame format SHALL be SYNC_BYTE, CMD, LEN, LEN payload bytes, CHK, where CHK = XOR of CMD, LEN and all payload bytes.
REQ-016 FSM states SHALL be IDLE, CMD, LEN, PAY, CHK; only bytes arriving with rx_done=1 advance the FSM.
REQ-017 IDLE: byte == SYNC_BYTE -> CMD; any other byte discarded, no error.
REQ-018 CMD: store byte in shadow cmd, init running XOR to byte -> LEN.
REQ-019 LEN: byte == 0 -> CHK; 1..MAX_LEN -> PAY, index cleared; byte > MAX_LEN -> frame_err pulse, IDLE.
REQ-020 PAY: each byte produces wr_en=1 the next cycle with wr_addr=index and wr_data=byte; index increments; after the LEN-th byte -> CHK.
REQ-021 SYNC_BYTE values inside CMD/LEN/PAY/CHK SHALL be treated as data, never as resync.
REQ-022 CHK: byte == running XOR -> frame_valid pulse the next cycle, cmd/len updated from shadow in that same cycle; mismatch -> frame_err pulse the next cycle, cmd/len unchanged; both -> IDLE.
REQ-023 cmd and len SHALL hold their values between frame_valid pulses; payload writes of a bad frame are not retracted.
REQ-024 Timeout counter SHALL clear on every rx_done and in IDLE; if it reaches TIMEOUT while not in IDLE -> frame_err pulse, IDLE.
REQ-025 rx_done in the same cycle the counter reaches TIMEOUT: the byte wins; no error, counter clears.
REQ-026 frame_valid and frame_err SHALL never be high in the same cycle; wr_en SHALL be 0 whenever neither a payload byte was accepted in the previous cycle.
REQ-027 Throughput: back-to-back rx_done on consecutive cycles SHALL be accepted without loss.

Reset
REQ-028 With rst=1 at a clk edge: state=IDLE, counter/index/XOR=0, cmd=0, len=0, wr_en=0, wr_addr=0, wr_data=0, frame_valid=0, frame_err=0.
REQ-029 Reset mid-frame SHALL abort silently (no frame_err), and the next frame SHALL be parsed normally.

Structure
REQ-030 SYNC_BYTE default, MAX_LEN default, TIMEOUT default and FSM state encodings SHALL live in shared header serial_defs.vh.
REQ-031 The inter-byte timeout counter SHALL be sub-module byte_timeout (ports clk, rst, clear, expired).
REQ-032 serial_r SHALL NOT be instantiated inside; the top level wires its data/done to rx_data/rx_done.

Verification
REQ-033 Bytes A5 01 02 11 22 30 -> wr (0,11), (1,22); frame_valid once; cmd=01, len=2.
REQ-034 Bytes A5 07 00 07 -> no wr_en; frame_valid; cmd=07, len=0.
REQ-035 Bytes A5 01 02 11 22 31 -> two writes, frame_err once, cmd/len keep prior values.
REQ-036 Bytes A5 01 11 -> frame_err immediately after LEN, no writes; following A5 02 00 02 -> frame_valid, cmd=02.
REQ-037 Bytes A5 01 then 2000 idle cycles -> frame_err exactly once at TIMEOUT; rx_done at cycle 2000 -> no error.
REQ-038 rst asserted after A5 01 02 11 -> all outputs 0, no frame_err; then A5 03 01 A5 A7 -> wr (0,A5), frame_valid, cmd=03, len=1.
